// File: rtl/typedef_pkg.sv
// Shared definitions for the vector issue queue.
// Holds the RISC-V V opcode / funct3 / mop encodings, the V_CU class map
// (bit indices and one-hot valid constants), the head FSM state type and
// the queue entry layout.
package typedef_pkg;

  localparam logic [6:0] OPC_V_LD    = 7'b0000111;
  localparam logic [6:0] OPC_V_ST    = 7'b0100111;
  localparam logic [6:0] OPC_V_ARITH = 7'b1010111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPFVV = 3'b001;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPIVX = 3'b100;
  localparam logic [2:0] F3_OPFVF = 3'b101;
  localparam logic [2:0] F3_OPMVX = 3'b110;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  localparam logic [1:0] MOP_UNIT      = 2'b00;
  localparam logic [1:0] MOP_IDX_UNORD = 2'b01;
  localparam logic [1:0] MOP_STRIDED   = 2'b10;
  localparam logic [1:0] MOP_IDX_ORD   = 2'b11;

  localparam int CLASS_W = 11;

  localparam int CLS_OPIVV     = 0;
  localparam int CLS_OPIVX     = 1;
  localparam int CLS_OPIVI     = 2;
  localparam int CLS_OPMVV     = 3;
  localparam int CLS_OPMVX     = 4;
  localparam int CLS_OPMVV_101 = 5;
  localparam int CLS_OPMVX_101 = 6;
  localparam int CLS_OPF       = 7;
  localparam int CLS_LOAD      = 8;
  localparam int CLS_LOAD_IDX  = 9;
  localparam int CLS_STORE     = 10;

  localparam logic [CLASS_W-1:0] OPIVV_VLD     = CLASS_W'(1) << CLS_OPIVV;
  localparam logic [CLASS_W-1:0] OPIVX_VLD     = CLASS_W'(1) << CLS_OPIVX;
  localparam logic [CLASS_W-1:0] OPIVI_VLD     = CLASS_W'(1) << CLS_OPIVI;
  localparam logic [CLASS_W-1:0] OPMVV_VLD     = CLASS_W'(1) << CLS_OPMVV;
  localparam logic [CLASS_W-1:0] OPMVX_VLD     = CLASS_W'(1) << CLS_OPMVX;
  localparam logic [CLASS_W-1:0] OPMVV_101_VLD = CLASS_W'(1) << CLS_OPMVV_101;
  localparam logic [CLASS_W-1:0] OPMVX_101_VLD = CLASS_W'(1) << CLS_OPMVX_101;
  localparam logic [CLASS_W-1:0] OPF_VLD       = CLASS_W'(1) << CLS_OPF;
  localparam logic [CLASS_W-1:0] LOAD_VLD      = CLASS_W'(1) << CLS_LOAD;
  localparam logic [CLASS_W-1:0] LOAD_IDX_VLD  = CLASS_W'(1) << CLS_LOAD_IDX;
  localparam logic [CLASS_W-1:0] STORE_VLD     = CLASS_W'(1) << CLS_STORE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MCU_REQ,
    ST_WAIT_BUF,
    ST_VCU_ISSUE,
    ST_IDX2_REQ
  } head_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  sew;
  } queue_entry_t;

  // Class of an OP-V arithmetic instruction. OPFVV/OPFVF share the FP
  // class. OPCFG (vsetvl*) is resolved by the scalar core and has no V_CU
  // class, so it returns zero and the head logic drops it as illegal.
  function automatic logic [CLASS_W-1:0] arith_class(input logic [2:0] funct3,
                                                     input logic [2:0] funct6_hi);
    logic [CLASS_W-1:0] cls;
    logic               hi101;
    hi101 = (funct6_hi == 3'b101);
    cls   = '0;
    case (funct3)
      F3_OPIVV: cls = OPIVV_VLD;
      F3_OPIVX: cls = OPIVX_VLD;
      F3_OPIVI: cls = OPIVI_VLD;
      F3_OPMVV: cls = hi101 ? OPMVV_101_VLD : OPMVV_VLD;
      F3_OPMVX: cls = hi101 ? OPMVX_101_VLD : OPMVX_VLD;
      F3_OPFVV: cls = OPF_VLD;
      F3_OPFVF: cls = OPF_VLD;
      default:  cls = '0;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/vector_issue_fifo.sv
// In-order storage for dispatched vector instructions.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears contents)
//   i_push, i_wdata   write an entry at the tail (ignored when full)
//   i_pop             drop the head entry (ignored when empty)
//   o_head            entry at the head pointer
//   o_full, o_empty   occupancy flags from the registered count
//   o_count           occupancy
module vector_issue_fifo
  import typedef_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  queue_entry_t     i_wdata,
  input  logic             i_pop,
  output queue_entry_t     o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  queue_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Contents are cleared on reset so the head-driven data outputs read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vector_issue_queue.sv
// DEPTH-entry issue queue between the scalar core's vector dispatch port
// and V_CU / M_CU. The head entry is decoded and issued in order: memory ops
// first run their M_CU descriptor handshake (and for loads wait for the
// buffered pulse), then every instruction is issued to V_CU on a one-hot
// class valid. Indexed-unordered loads are expanded into a second,
// unit-stride part before the entry is popped.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   vector_instr_vld_i/_i, rs1_i,
//   rs2_i, sew_i                      dispatch (accepted when not stalled)
//   vector_stall_o                    queue full
//   instr_vld_o / instr_rdy_i         one-hot class issue handshake to V_CU
//   vector_instr_o                    head instruction (part 2 when expanded)
//   mcu_ld_*, mcu_st_*                M_CU load/store descriptor handshakes
//   mcu_base_addr_o .. mcu_idx_ld_st_o descriptor fields of the head
//   illegal_o                         pulse: unrecognised head dropped
//   q_count_o                         occupancy
//   dbg_state_o                       head FSM state
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; once raised, a valid and its data stay unchanged until that cycle.
module vector_issue_queue
  import typedef_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int NUM_CLASSES = 11,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vector_instr_vld_i,
  input  logic [31:0]            vector_instr_i,
  input  logic [31:0]            rs1_i,
  input  logic [31:0]            rs2_i,
  input  logic [1:0]             sew_i,
  output logic                   vector_stall_o,
  input  logic [NUM_CLASSES-1:0] instr_rdy_i,
  output logic [NUM_CLASSES-1:0] instr_vld_o,
  output logic [31:0]            vector_instr_o,
  output logic                   mcu_ld_vld_o,
  input  logic                   mcu_ld_rdy_i,
  input  logic                   mcu_ld_buffered_i,
  output logic                   mcu_st_vld_o,
  input  logic                   mcu_st_rdy_i,
  output logic [31:0]            mcu_base_addr_o,
  output logic [31:0]            mcu_stride_o,
  output logic [2:0]             mcu_data_width_o,
  output logic                   mcu_unit_ld_st_o,
  output logic                   mcu_strided_ld_st_o,
  output logic                   mcu_idx_ld_st_o,
  output logic                   illegal_o,
  output logic [CNT_W-1:0]       q_count_o,
  output head_state_t            dbg_state_o
);

  head_state_t r_state;
  head_state_t w_next_state;
  logic        r_part2;

  queue_entry_t     w_wdata;
  queue_entry_t     w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;

  logic [31:0]            w_part2_instr;
  logic [31:0]            w_instr;
  logic [6:0]             w_opc;
  logic [1:0]             w_mop;
  logic                   w_is_ld;
  logic                   w_is_st;
  logic                   w_is_mem;
  logic [CLASS_W-1:0]     w_class;
  logic [NUM_CLASSES-1:0] w_class_vec;
  logic [NUM_CLASSES-1:0] w_instr_vld;
  logic                   w_issue_hs;
  logic                   w_ld_vld;
  logic                   w_st_vld;
  logic                   w_illegal;
  logic                   w_set_part2;
  logic                   w_clr_part2;

  assign w_wdata = '{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i, sew: sew_i};
  assign w_push  = vector_instr_vld_i && !w_full;

  vector_issue_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Part 2 of an indexed load: mop forced to unit-stride and the width field
  // replaced by the SEW captured at dispatch (zero-extended to 3 bits).
  assign w_part2_instr = {w_head.instr[31:28], 2'b00, w_head.instr[25:15],
                          1'b0, w_head.sew, w_head.instr[11:0]};
  assign w_instr  = r_part2 ? w_part2_instr : w_head.instr;
  assign w_opc    = w_instr[6:0];
  assign w_mop    = w_instr[27:26];
  assign w_is_ld  = (w_opc == OPC_V_LD);
  assign w_is_st  = (w_opc == OPC_V_ST);
  assign w_is_mem = w_is_ld || w_is_st;

  always_comb begin
    w_class = '0;
    if (w_is_ld) begin
      w_class = (w_mop == MOP_IDX_UNORD) ? LOAD_IDX_VLD : LOAD_VLD;
    end else if (w_is_st) begin
      w_class = STORE_VLD;
    end else if (w_opc == OPC_V_ARITH) begin
      w_class = arith_class(w_instr[14:12], w_instr[31:29]);
    end
  end

  assign w_class_vec = NUM_CLASSES'(w_class);
  assign w_issue_hs  = |(w_instr_vld & instr_rdy_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_part2 <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_part2) begin
        r_part2 <= 1'b1;
      end else if (w_clr_part2) begin
        r_part2 <= 1'b0;
      end
    end
  end

  // Arithmetic heads are offered to V_CU straight from IDLE so a freshly
  // enqueued instruction issues the next cycle and back-to-back issue runs
  // at one per cycle; VCU_ISSUE only holds an offer that was not taken.
  always_comb begin
    w_next_state = r_state;
    w_instr_vld  = '0;
    w_ld_vld     = 1'b0;
    w_st_vld     = 1'b0;
    w_pop        = 1'b0;
    w_illegal    = 1'b0;
    w_set_part2  = 1'b0;
    w_clr_part2  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_is_mem) begin
            w_next_state = ST_MCU_REQ;
          end else if (w_class != '0) begin
            w_instr_vld = w_class_vec;
            if (w_issue_hs) begin
              w_pop = 1'b1;
            end else begin
              w_next_state = ST_VCU_ISSUE;
            end
          end else begin
            w_pop     = 1'b1;
            w_illegal = 1'b1;
          end
        end
      end
      ST_MCU_REQ: begin
        if (w_is_ld) begin
          w_ld_vld = 1'b1;
          if (mcu_ld_rdy_i) begin
            w_next_state = ST_WAIT_BUF;
          end
        end else begin
          w_st_vld = 1'b1;
          if (mcu_st_rdy_i) begin
            w_next_state = ST_VCU_ISSUE;
          end
        end
      end
      ST_WAIT_BUF: begin
        if (mcu_ld_buffered_i) begin
          w_next_state = ST_VCU_ISSUE;
        end
      end
      ST_VCU_ISSUE: begin
        w_instr_vld = w_class_vec;
        if (w_issue_hs) begin
          // Part 2 has mop=unit, so this only fires for part 1.
          if (w_is_ld && (w_mop == MOP_IDX_UNORD)) begin
            w_set_part2  = 1'b1;
            w_next_state = ST_IDX2_REQ;
          end else begin
            w_pop        = 1'b1;
            w_clr_part2  = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_IDX2_REQ: begin
        w_next_state = ST_MCU_REQ;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign vector_stall_o      = w_full;
  assign instr_vld_o         = w_instr_vld;
  assign vector_instr_o      = w_instr;
  assign mcu_ld_vld_o        = w_ld_vld;
  assign mcu_st_vld_o        = w_st_vld;
  assign mcu_base_addr_o     = w_head.rs1;
  assign mcu_stride_o        = w_head.rs2;
  assign mcu_data_width_o    = w_instr[14:12];
  assign mcu_unit_ld_st_o    = w_is_mem && (w_mop == MOP_UNIT);
  assign mcu_strided_ld_st_o = w_is_mem && (w_mop == MOP_STRIDED);
  assign mcu_idx_ld_st_o     = w_is_mem && (w_mop == MOP_IDX_UNORD);
  assign illegal_o           = w_illegal;
  assign q_count_o           = w_count;
  assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_vector_issue_queue.sv
module tb_vector_issue_queue;
  import typedef_pkg::*;

  localparam int DEPTH = 4;
  localparam int NC    = 11;
  localparam int CW    = 3;

  // Expected one-hot class values, written out by hand.
  localparam logic [10:0] E_OPIVV  = 11'h001;
  localparam logic [10:0] E_OPIVX  = 11'h002;
  localparam logic [10:0] E_OPIVI  = 11'h004;
  localparam logic [10:0] E_OPMVV  = 11'h008;
  localparam logic [10:0] E_OPMVX  = 11'h010;
  localparam logic [10:0] E_MVV101 = 11'h020;
  localparam logic [10:0] E_MVX101 = 11'h040;
  localparam logic [10:0] E_OPF    = 11'h080;
  localparam logic [10:0] E_LOAD   = 11'h100;
  localparam logic [10:0] E_LDIDX  = 11'h200;
  localparam logic [10:0] E_STORE  = 11'h400;

  logic          clk;
  logic          rst;
  logic          vector_instr_vld_i;
  logic [31:0]   vector_instr_i;
  logic [31:0]   rs1_i;
  logic [31:0]   rs2_i;
  logic [1:0]    sew_i;
  logic          vector_stall_o;
  logic [NC-1:0] instr_rdy_i;
  logic [NC-1:0] instr_vld_o;
  logic [31:0]   vector_instr_o;
  logic          mcu_ld_vld_o;
  logic          mcu_ld_rdy_i;
  logic          mcu_ld_buffered_i;
  logic          mcu_st_vld_o;
  logic          mcu_st_rdy_i;
  logic [31:0]   mcu_base_addr_o;
  logic [31:0]   mcu_stride_o;
  logic [2:0]    mcu_data_width_o;
  logic          mcu_unit_ld_st_o;
  logic          mcu_strided_ld_st_o;
  logic          mcu_idx_ld_st_o;
  logic          illegal_o;
  logic [CW-1:0] q_count_o;
  head_state_t   dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  vector_issue_queue #(.DEPTH(DEPTH), .NUM_CLASSES(NC), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .vector_instr_vld_i  (vector_instr_vld_i),
    .vector_instr_i      (vector_instr_i),
    .rs1_i               (rs1_i),
    .rs2_i               (rs2_i),
    .sew_i               (sew_i),
    .vector_stall_o      (vector_stall_o),
    .instr_rdy_i         (instr_rdy_i),
    .instr_vld_o         (instr_vld_o),
    .vector_instr_o      (vector_instr_o),
    .mcu_ld_vld_o        (mcu_ld_vld_o),
    .mcu_ld_rdy_i        (mcu_ld_rdy_i),
    .mcu_ld_buffered_i   (mcu_ld_buffered_i),
    .mcu_st_vld_o        (mcu_st_vld_o),
    .mcu_st_rdy_i        (mcu_st_rdy_i),
    .mcu_base_addr_o     (mcu_base_addr_o),
    .mcu_stride_o        (mcu_stride_o),
    .mcu_data_width_o    (mcu_data_width_o),
    .mcu_unit_ld_st_o    (mcu_unit_ld_st_o),
    .mcu_strided_ld_st_o (mcu_strided_ld_st_o),
    .mcu_idx_ld_st_o     (mcu_idx_ld_st_o),
    .illegal_o           (illegal_o),
    .q_count_o           (q_count_o),
    .dbg_state_o         (dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [1:0] sew);
    vector_instr_vld_i = vld;
    vector_instr_i     = instr;
    rs1_i              = rs1;
    rs2_i              = rs2;
    sew_i              = sew;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_arith(input logic [5:0] f6, input logic [2:0] f3);
    return {f6, 1'b1, 5'd2, 5'd1, f3, 5'd3, 7'h57};
  endfunction

  function automatic logic [31:0] mk_mem(input logic [6:0] opc, input logic [1:0] mop,
                                         input logic [2:0] width);
    return {3'b000, 1'b0, mop, 1'b1, 5'd0, 5'd5, width, 5'd4, opc};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [10:0] exp_vld;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] ins[5];
  logic [31:0] ld_i;
  logic [31:0] p2_i;

  initial begin
    // Vector table
    vecs[0] = '{"opivv",     mk_arith(6'b000000, 3'b000), E_OPIVV,  1'b0};
    vecs[1] = '{"opivx",     mk_arith(6'b000000, 3'b100), E_OPIVX,  1'b0};
    vecs[2] = '{"opivi",     mk_arith(6'b000000, 3'b011), E_OPIVI,  1'b0};
    vecs[3] = '{"opmvv",     mk_arith(6'b010000, 3'b010), E_OPMVV,  1'b0};
    vecs[4] = '{"opmvx",     mk_arith(6'b001110, 3'b110), E_OPMVX,  1'b0};
    vecs[5] = '{"opmvv_101", mk_arith(6'b101101, 3'b010), E_MVV101, 1'b0};
    vecs[6] = '{"opmvx_101", mk_arith(6'b101001, 3'b110), E_MVX101, 1'b0};
    vecs[7] = '{"opfvv",     mk_arith(6'b000000, 3'b001), E_OPF,    1'b0};
    vecs[8] = '{"opfvf",     mk_arith(6'b000000, 3'b101), E_OPF,    1'b0};
    vecs[9] = '{"illegal33", 32'h00B50533,                11'h000,  1'b1};

    rst               = 1'b1;
    instr_rdy_i       = '1;
    mcu_ld_rdy_i      = 1'b0;
    mcu_ld_buffered_i = 1'b0;
    mcu_st_rdy_i      = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b0);
    tick();
    tick();
    check("rst_count", 64'(q_count_o), 64'd0);
    check("rst_vld", 64'(instr_vld_o), 64'd0);
    check("rst_stall", 64'(vector_stall_o), 64'd0);
    check("rst_instr", 64'(vector_instr_o), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven decode: one instruction at a time, V_CU always ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, 32'h0, 32'h0, 2'b00);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
      check({vecs[i].name, "_vld"}, 64'(instr_vld_o), 64'(vecs[i].exp_vld));
      check({vecs[i].name, "_illegal"}, 64'(illegal_o), 64'(vecs[i].exp_illegal));
      if (!vecs[i].exp_illegal) begin
        check({vecs[i].name, "_instr"}, 64'(vector_instr_o), 64'(vecs[i].instr));
      end
      tick();
      check({vecs[i].name, "_drained"}, 64'(q_count_o), 64'd0);
      check({vecs[i].name, "_illegal_off"}, 64'(illegal_o), 64'd0);
    end

    // Three OPIVV back-to-back: issue in each of the following cycles.
    for (int k = 0; k < 3; k++) ins[k] = mk_arith(6'b000000, 3'b000) | (32'(k + 8) << 7);
    drive(1'b1, ins[0], 32'h0, 32'h0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) drive(1'b1, ins[k + 1], 32'h0, 32'h0, 2'b00);
      else drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
      check("b2b_vld", 64'(instr_vld_o), 64'(E_OPIVV));
      check("b2b_instr", 64'(vector_instr_o), 64'(ins[k]));
      check("b2b_count", 64'(q_count_o), 64'd1);
    end
    tick();
    check("b2b_empty_vld", 64'(instr_vld_o), 64'd0);
    check("b2b_empty_count", 64'(q_count_o), 64'd0);

    // Fill to DEPTH with V_CU stalled; 5th dispatch held until space frees.
    instr_rdy_i = '0;
    for (int k = 0; k < 5; k++) ins[k] = mk_arith(6'b000000, 3'b000) | (32'(k + 16) << 7);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ins[k], 32'h0, 32'h0, 2'b00);
      tick();
    end
    check("full_stall", 64'(vector_stall_o), 64'd1);
    check("full_count", 64'(q_count_o), 64'd4);
    check("full_offer", 64'(instr_vld_o), 64'(E_OPIVV));
    drive(1'b1, ins[4], 32'h0, 32'h0, 2'b00);
    tick();
    check("full_reject_count", 64'(q_count_o), 64'd4);
    check("full_reject_stall", 64'(vector_stall_o), 64'd1);
    instr_rdy_i = '1;
    tick();
    check("first_pop_count", 64'(q_count_o), 64'd3);
    check("first_pop_stall", 64'(vector_stall_o), 64'd0);
    check("first_pop_head", 64'(vector_instr_o), 64'(ins[1]));
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    check("fifth_accept_count", 64'(q_count_o), 64'd3);
    for (int k = 2; k < 5; k++) begin
      check("drain_head", 64'(vector_instr_o), 64'(ins[k]));
      tick();
    end
    check("drain_count", 64'(q_count_o), 64'd0);

    // Unit-stride load.
    ld_i = mk_mem(7'h07, 2'b00, 3'b110);
    mcu_ld_rdy_i = 1'b1;
    drive(1'b1, ld_i, 32'h1000, 32'h4, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    check("ld_idle_ldvld", 64'(mcu_ld_vld_o), 64'd0);
    tick();
    check("ld_req_vld", 64'(mcu_ld_vld_o), 64'd1);
    check("ld_req_base", 64'(mcu_base_addr_o), 64'h1000);
    check("ld_req_stride", 64'(mcu_stride_o), 64'h4);
    check("ld_req_unit", 64'(mcu_unit_ld_st_o), 64'd1);
    check("ld_req_strided", 64'(mcu_strided_ld_st_o), 64'd0);
    check("ld_req_width", 64'(mcu_data_width_o), 64'h6);
    check("ld_req_noissue", 64'(instr_vld_o), 64'd0);
    tick();
    check("ld_wait_ldvld", 64'(mcu_ld_vld_o), 64'd0);
    check("ld_wait_noissue", 64'(instr_vld_o), 64'd0);
    tick();
    check("ld_wait2_noissue", 64'(instr_vld_o), 64'd0);
    mcu_ld_buffered_i = 1'b1;
    tick();
    mcu_ld_buffered_i = 1'b0;
    check("ld_issue_vld", 64'(instr_vld_o), 64'(E_LOAD));
    tick();
    check("ld_popped", 64'(q_count_o), 64'd0);
    check("ld_done_vld", 64'(instr_vld_o), 64'd0);

    // Indexed-unordered load, sew=2: two-part expansion, single pop.
    ld_i = mk_mem(7'h07, 2'b01, 3'b101);
    p2_i = mk_mem(7'h07, 2'b00, 3'b010);
    drive(1'b1, ld_i, 32'h2000, 32'h8, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    tick();
    check("idx1_req_vld", 64'(mcu_ld_vld_o), 64'd1);
    check("idx1_req_idx", 64'(mcu_idx_ld_st_o), 64'd1);
    check("idx1_req_width", 64'(mcu_data_width_o), 64'h5);
    tick();
    mcu_ld_buffered_i = 1'b1;
    tick();
    mcu_ld_buffered_i = 1'b0;
    check("idx1_issue", 64'(instr_vld_o), 64'(E_LDIDX));
    tick();
    check("idx2_nopop", 64'(q_count_o), 64'd1);
    check("idx2_noissue", 64'(instr_vld_o), 64'd0);
    check("idx2_instr", 64'(vector_instr_o), 64'(p2_i));
    tick();
    check("idx2_req_vld", 64'(mcu_ld_vld_o), 64'd1);
    check("idx2_req_unit", 64'(mcu_unit_ld_st_o), 64'd1);
    check("idx2_req_idx", 64'(mcu_idx_ld_st_o), 64'd0);
    check("idx2_req_width", 64'(mcu_data_width_o), 64'h2);
    check("idx2_req_base", 64'(mcu_base_addr_o), 64'h2000);
    tick();
    mcu_ld_buffered_i = 1'b1;
    tick();
    mcu_ld_buffered_i = 1'b0;
    check("idx2_issue", 64'(instr_vld_o), 64'(E_LOAD));
    tick();
    check("idx_popped", 64'(q_count_o), 64'd0);

    // Strided store with M_CU back-pressure for three cycles.
    ld_i = mk_mem(7'h27, 2'b10, 3'b110);
    mcu_st_rdy_i = 1'b0;
    drive(1'b1, ld_i, 32'h3000, 32'h10, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("st_hold_vld", 64'(mcu_st_vld_o), 64'd1);
      check("st_hold_base", 64'(mcu_base_addr_o), 64'h3000);
      check("st_hold_stride", 64'(mcu_stride_o), 64'h10);
      check("st_hold_strided", 64'(mcu_strided_ld_st_o), 64'd1);
      check("st_hold_noissue", 64'(instr_vld_o), 64'd0);
      tick();
    end
    mcu_st_rdy_i = 1'b1;
    check("st_accept_vld", 64'(mcu_st_vld_o), 64'd1);
    tick();
    mcu_st_rdy_i = 1'b0;
    check("st_issue", 64'(instr_vld_o), 64'(E_STORE));
    check("st_issue_stvld", 64'(mcu_st_vld_o), 64'd0);
    tick();
    check("st_popped", 64'(q_count_o), 64'd0);

    // Reset while a load waits for its buffered pulse.
    drive(1'b1, mk_mem(7'h07, 2'b00, 3'b110), 32'h4000, 32'h4, 2'b00);
    tick();
    drive(1'b1, mk_arith(6'b000000, 3'b000), 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    tick();
    check("pre_rst_count", 64'(q_count_o), 64'd2);
    check("pre_rst_ldvld", 64'(mcu_ld_vld_o), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 64'(q_count_o), 64'd0);
    check("mid_rst_vld", 64'(instr_vld_o), 64'd0);
    check("mid_rst_ldvld", 64'(mcu_ld_vld_o), 64'd0);
    check("mid_rst_stvld", 64'(mcu_st_vld_o), 64'd0);
    check("mid_rst_illegal", 64'(illegal_o), 64'd0);
    check("mid_rst_instr", 64'(vector_instr_o), 64'd0);
    check("mid_rst_base", 64'(mcu_base_addr_o), 64'd0);
    check("mid_rst_unit", 64'(mcu_unit_ld_st_o), 64'd0);
    check("mid_rst_width", 64'(mcu_data_width_o), 64'd0);
    mcu_ld_buffered_i = 1'b1;
    tick();
    mcu_ld_buffered_i = 1'b0;
    check("stray_buf_vld", 64'(instr_vld_o), 64'd0);

    // Queue works again after reset.
    drive(1'b1, mk_arith(6'b000000, 3'b100), 32'h0, 32'h0, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    check("post_rst_issue", 64'(instr_vld_o), 64'(E_OPIVX));
    tick();
    check("post_rst_count", 64'(q_count_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
